// File: rtl/uart_tx_sched.sv
`default_nettype none
//==============================================================================
// Module   : uart_tx_sched
// Desc     : Round-robin scheduler sharing one byte-wide UART transmitter among
//            N requesters, with per-requester lock, inter-frame gap and a
//            sticky error when the transmitter never reports busy.
// Revision : 1.0  initial release
//==============================================================================
module uart_tx_sched #(
    parameter int N          = 4,
    parameter int GAP_CYCLES = 0,
    parameter int HI_TIMEOUT = 3
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
    input  logic [N-1:0]         req_lock,
    output logic [N-1:0]         req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 sched_busy,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int c_IDW = $clog2(N);
    localparam int c_TOW = (HI_TIMEOUT > 1) ? $clog2(HI_TIMEOUT) : 1;

    localparam logic [c_IDW:0]   c_N        = (c_IDW+1)'(N);
    localparam logic [c_IDW-1:0] c_LAST_ID  = c_IDW'(N - 1);
    localparam logic [c_TOW-1:0] c_TO_LAST  = c_TOW'((HI_TIMEOUT > 0) ? HI_TIMEOUT - 1 : 0);
    localparam logic [7:0]       c_GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LAUNCH  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_HI = 3'd2;
    localparam logic [2:0] c_ST_WAIT_LO = 3'd3;
    localparam logic [2:0] c_ST_GAP     = 3'd4;
    localparam logic [2:0] c_ST_AFTER   = (GAP_CYCLES > 0) ? c_ST_GAP : c_ST_IDLE;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] r_grant_id;
    logic             r_lock_hold;
    logic [7:0]       r_tx_data;
    logic             r_err;
    logic [c_TOW-1:0] r_to_cnt;
    logic [7:0]       r_gap_cnt;

    logic [7:0]       w_data [N];
    logic [c_IDW:0]   w_sum;
    logic [c_IDW-1:0] w_rr_idx;
    logic             w_rr_found;
    logic             w_hold_win;
    logic [c_IDW-1:0] w_win;
    logic             w_accept;
    logic             w_to_expire;
    logic [N-1:0]     w_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_data[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Descending scan so the last hit is the first valid index at or after r_ptr.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_sum      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (c_IDW+1)'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            if (req_valid[w_sum[c_IDW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_sum[c_IDW-1:0];
            end
        end
    end

    assign w_hold_win  = r_lock_hold & req_valid[r_grant_id];
    assign w_win       = w_hold_win ? r_grant_id : w_rr_idx;
    assign w_accept    = (r_state == c_ST_IDLE) & w_rr_found;
    assign w_to_expire = (r_state == c_ST_WAIT_HI) & ~tx_busy & (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_ready = '0;
        if (w_accept && srst_n) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_LAUNCH;
                end
            end
            c_ST_LAUNCH: begin
                w_state_nxt = c_ST_WAIT_HI;
            end
            c_ST_WAIT_HI: begin
                if (tx_busy) begin
                    w_state_nxt = c_ST_WAIT_LO;
                end else if (w_to_expire) begin
                    w_state_nxt = c_ST_AFTER;
                end
            end
            c_ST_WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_nxt = c_ST_AFTER;
                end
            end
            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_lock_hold <= 1'b0;
            r_tx_data   <= '0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_tx_data  <= w_data[w_win];
                r_grant_id <= w_win;
                r_ptr      <= (w_win == c_LAST_ID) ? '0 : w_win + 1'b1;
            end
            // An idle cycle without an accept means the holder is gone, so the lock drops.
            if (r_state == c_ST_IDLE) begin
                r_lock_hold <= w_accept & req_lock[w_win];
            end
            r_to_cnt  <= ((r_state == c_ST_WAIT_HI) && !tx_busy) ? r_to_cnt + 1'b1 : '0;
            r_gap_cnt <= (r_state == c_ST_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
            if (err_clr) begin
                r_err <= 1'b0;
            end else if (w_to_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready  = w_ready;
    assign tx_start   = (r_state == c_ST_LAUNCH);
    assign tx_data    = r_tx_data;
    assign grant_id   = r_grant_id;
    assign sched_busy = (r_state != c_ST_IDLE);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_tx_sched
// Desc     : Randomized scoreboard bench for uart_tx_sched with a 10-bit-time
//            transmitter model and a serial-line receiver.
// Revision : 1.0  initial release
//==============================================================================
module tb_uart_tx_sched;

    localparam int N      = 4;
    localparam int GAP    = 3;
    localparam int HIT    = 3;
    localparam int TX_LEN = 10;

    logic           clk = 1'b0;
    logic           srst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           sched_busy;
    logic           err;
    logic           err_clr;

    always #5 clk = ~clk;

    uart_tx_sched #(.N(N), .GAP_CYCLES(GAP), .HI_TIMEOUT(HIT)) dut (
        .clk       (clk),
        .srst_n    (srst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .sched_busy(sched_busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: busy for TX_LEN cycles starting the cycle after start.
    bit         tx_dead = 1'b0;
    int         tx_cnt;
    logic [7:0] tx_shift;
    logic       ser;
    logic [7:0] rx_byte;

    always @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            tx_cnt   <= 0;
            tx_shift <= 8'h00;
        end else begin
            if (tx_start && !tx_dead) tx_cnt <= TX_LEN;
            else if (tx_cnt > 0)      tx_cnt <= tx_cnt - 1;
            if (tx_cnt == TX_LEN)     tx_shift <= tx_data;
        end
    end

    assign tx_busy = (tx_cnt != 0);

    always_comb begin
        ser = 1'b1;
        if (tx_cnt == TX_LEN)               ser = 1'b0;
        else if (tx_cnt >= 2 && tx_cnt <= 9) ser = tx_shift[9 - tx_cnt];
    end

    typedef struct {int id; int data;} exp_t;
    exp_t exp_q[$];

    // Monitor: rebuild each byte from the serial line and score it.
    always @(negedge clk) begin
        if (srst_n) begin
            if (tx_cnt == TX_LEN) chk("start_bit", int'(ser), 0);
            if (tx_cnt >= 2 && tx_cnt <= 9) rx_byte[9 - tx_cnt] <= ser;
            if (tx_cnt == 1) begin
                chk("stop_bit", int'(ser), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("serial_byte", int'(rx_byte), e.data);
                    chk("frame_grant", int'(grant_id), e.id);
                    chk("tx_data_hold", int'(tx_data), e.data);
                end
            end
        end
    end

    // Stimulus storage and reference-model state.
    logic [8:0] sbuf [N][256];
    int  hd [N];
    int  tl [N];
    int  p_valid    = 100;
    bit  clr_now    = 1'b0;
    bit  clr_on_set = 1'b0;
    int  cyc        = 0;
    int  next_ok    = 0;
    int  acc_c      = -1000;
    bit  acc_dead   = 1'b0;
    int  acc_byte   = 0;
    int  acc_w      = 0;
    int  m_ptr      = 0;
    int  m_holder   = 0;
    bit  m_lock     = 1'b0;
    bit  m_err      = 1'b0;

    task automatic push_byte(input int r, input bit lk, input logic [7:0] d);
        if (tl[r] < 255) begin
            sbuf[r][tl[r]] = {lk, d};
            tl[r]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit v;
            v = (hd[i] < tl[i]) && ($urandom_range(0, 99) < p_valid);
            req_valid[i]     = v;
            req_data[8*i +: 8] = v ? sbuf[i][hd[i]][7:0] : 8'($urandom);
            req_lock[i]      = v ? sbuf[i][hd[i]][8] : 1'b0;
        end
        err_clr = clr_now || (clr_on_set && acc_dead && (cyc == acc_c + 1 + HIT));
        clr_now = 1'b0;
    endtask

    task automatic check_cycle();
        bit           idle;
        bit           found;
        int           w;
        logic [N-1:0] exp_ready;
        idle      = (cyc >= next_ok);
        found     = 1'b0;
        w         = 0;
        exp_ready = '0;
        if (idle) begin
            if (m_lock && req_valid[m_holder]) begin
                found = 1'b1;
                w     = m_holder;
            end else begin
                m_lock = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        w     = idx;
                    end
                end
            end
            if (found) exp_ready[w] = 1'b1;
        end
        chk("req_ready", int'(req_ready), int'(exp_ready));
        chk("sched_busy", int'(sched_busy), int'(!idle));
        chk("tx_start", int'(tx_start), int'(cyc == acc_c + 1));
        if (cyc == acc_c + 1) begin
            chk("grant_id", int'(grant_id), acc_w);
            chk("tx_data", int'(tx_data), acc_byte);
        end
        chk("err", int'(err), int'(m_err));
        if (err_clr)                                m_err = 1'b0;
        else if (acc_dead && cyc == acc_c + 1 + HIT) m_err = 1'b1;
        if (found) begin
            acc_c    = cyc;
            acc_w    = w;
            acc_byte = int'(sbuf[w][hd[w]][7:0]);
            m_lock   = sbuf[w][hd[w]][8];
            m_holder = w;
            m_ptr    = (w + 1) % N;
            hd[w]++;
            acc_dead = tx_dead;
            if (!tx_dead) exp_q.push_back('{id: w, data: acc_byte});
            next_ok  = cyc + (tx_dead ? 2 + HIT : 3 + TX_LEN) + GAP;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        check_cycle();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = (cyc < next_ok);
        for (int i = 0; i < N; i++) if (hd[i] < tl[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drain();
        int g;
        g = 0;
        while (pending() && g < 3000) begin
            step();
            g++;
        end
        if (g >= 3000) chk("drain_timeout", 1, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_sched_busy", int'(sched_busy), 0);
        chk("rst_err", int'(err), 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr    = 0;
        m_holder = 0;
        m_lock   = 1'b0;
        m_err    = 1'b0;
        acc_c    = -1000;
        acc_dead = 1'b0;
        next_ok  = cyc;
    endtask

    task automatic load_random(input int n);
        for (int j = 0; j < n; j++) begin
            push_byte($urandom_range(0, N - 1), ($urandom_range(0, 3) == 0), 8'($urandom));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int g;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        srst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        err_clr   = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        model_reset();

        // Single byte 0xA5 from requester 0.
        push_byte(0, 1'b0, 8'hA5);
        drain();

        // Round-robin with everyone continuously valid.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_byte(i, 1'b0, 8'($urandom));
        drain();

        // Locked three-byte packet from requester 2 competing with 0 and 1.
        push_byte(2, 1'b1, 8'h11);
        push_byte(2, 1'b1, 8'h22);
        push_byte(2, 1'b0, 8'h33);
        push_byte(0, 1'b0, 8'h44);
        push_byte(1, 1'b0, 8'h55);
        drain();

        // Random traffic with intermittent valids and random locks.
        p_valid = 60;
        load_random(40);
        repeat (250) step();
        drain();

        // Transmitter never goes busy: sticky error, then clear.
        p_valid = 100;
        tx_dead = 1'b1;
        push_byte(0, 1'b0, 8'h5A);
        push_byte(2, 1'b1, 8'hC3);
        push_byte(2, 1'b0, 8'h3C);
        drain();
        clr_now = 1'b1;
        step();
        step();
        clr_on_set = 1'b1;
        push_byte(1, 1'b0, 8'h77);
        push_byte(3, 1'b0, 8'h88);
        drain();
        clr_on_set = 1'b0;
        tx_dead    = 1'b0;
        push_byte(1, 1'b0, 8'h99);
        push_byte(3, 1'b0, 8'hE1);
        drain();

        // Asynchronous reset six cycles into a frame.
        push_byte(1, 1'b0, 8'hB7);
        push_byte(3, 1'b0, 8'h6D);
        a0 = acc_c;
        g  = 0;
        while (!(acc_c != a0 && cyc == acc_c + 6) && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) chk("reset_setup_timeout", 1, 0);
        srst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        cyc++;
        model_reset();
        drain();

        // More random traffic after reset.
        p_valid = 80;
        load_random(30);
        repeat (150) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
